period_sequencer: RTL and testbench

//  Central FSM sequencing one level: prelim -> game -> answer -> post -> judge.

---
 rtl/period_sequencer_pkg.sv | 13 +
 rtl/period_sequencer_sec_tick_gen.sv | 18 +
 rtl/period_sequencer.sv | 144 ++++++++++++++
 tb/tb_period_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/period_sequencer_pkg.sv
// period_sequencer_pkg: state encoding, default phase durations and level limits
package period_sequencer_pkg;
    typedef enum logic [2:0] {IDLE, PRE, GAME, ANSWER, POST, JUDGE, OVER} seqState;
    localparam int DEF_PRE_SECS    = 3;
    localparam int DEF_GAME_SECS   = 10;
    localparam int DEF_ANSWER_SECS = 5;
    localparam int DEF_POST_SECS   = 3;
    localparam int DEF_MAX_LEVEL   = 9;
    localparam int DEF_JUDGE_TO    = 16;
    function automatic logic isTimed(seqState s);
        return s inside {PRE, GAME, ANSWER, POST};
    endfunction
endpackage

// File: rtl/period_sequencer_sec_tick_gen.sv
// period_sequencer_sec_tick_gen: synchronizes Clk1Hz and emits a 1-cycle tick per rising edge
module period_sequencer_sec_tick_gen (
    input  logic Clk100M,
    input  logic reset,
    input  logic Clk1Hz,
    output logic secTick
);
    logic [2:0] syncQ;
    always_ff @(posedge Clk100M) begin
        if (reset) begin
            syncQ   <= '0;
            secTick <= 1'b0;
        end else begin
            syncQ   <= {syncQ[1:0], Clk1Hz};
            secTick <= syncQ[1] & ~syncQ[2];
        end
    end
endmodule

// File: rtl/period_sequencer.sv
// period_sequencer: level FSM prelim -> game -> answer -> post -> judge with phase timers
module period_sequencer
    import period_sequencer_pkg::*;
#(
    parameter int PRE_SECS    = DEF_PRE_SECS,
    parameter int GAME_SECS   = DEF_GAME_SECS,
    parameter int ANSWER_SECS = DEF_ANSWER_SECS,
    parameter int POST_SECS   = DEF_POST_SECS,
    parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
    parameter int JUDGE_TO    = DEF_JUDGE_TO
) (
    input  logic       Clk100M,
    input  logic       reset,
    input  logic       Clk1Hz,
    input  logic       startBtn,
    input  logic       incLevel,
    input  logic       lose,
    output logic       prelimSig,
    output logic       gameSig,
    output logic       answerSig,
    output logic       postSig,
    output logic       startGen,
    output logic       stopGen,
    output logic       stopCount,
    output logic       levelComplete,
    output logic       pre,
    output logic       game,
    output logic       answer,
    output logic       post,
    output logic [7:0] secsLeft,
    output logic [3:0] curLevel,
    output logic       gameOver,
    output logic       win
);
    localparam int CW = $clog2(JUDGE_TO + 1);

    seqState        stateQ, stateD;
    logic [7:0]     secsD;
    logic [3:0]     levelD;
    logic           winD, enter, expire, secTick;
    logic [CW-1:0]  waitQ, waitD;

    period_sequencer_sec_tick_gen tickGen (
        .Clk100M(Clk100M),
        .reset  (reset),
        .Clk1Hz (Clk1Hz),
        .secTick(secTick)
    );

    function automatic logic [7:0] phaseSecs(seqState s);
        return s == PRE    ? 8'(PRE_SECS)    :
               s == GAME   ? 8'(GAME_SECS)   :
               s == ANSWER ? 8'(ANSWER_SECS) :
               s == POST   ? 8'(POST_SECS)   : 8'd0;
    endfunction

    assign expire = secTick && secsLeft == 8'd1;

    always_comb begin
        stateD = stateQ;
        levelD = curLevel;
        winD   = win;
        waitD  = waitQ;
        case (stateQ)
            IDLE:   stateD = startBtn ? PRE : IDLE;
            PRE:    stateD = expire ? GAME : PRE;
            GAME:   stateD = expire ? ANSWER : GAME;
            ANSWER: stateD = expire ? POST : ANSWER;
            POST:   stateD = expire ? JUDGE : POST;
            JUDGE: begin
                if (lose) begin
                    stateD = OVER;
                    winD   = 1'b0;
                end else if (incLevel) begin
                    if (curLevel < 4'(MAX_LEVEL)) begin
                        levelD = curLevel + 4'd1;
                        stateD = PRE;
                    end else begin
                        stateD = OVER;
                        winD   = 1'b1;
                    end
                end else if (waitQ == CW'(JUDGE_TO - 1)) begin
                    stateD = OVER;
                end else begin
                    waitD = waitQ + CW'(1);
                end
            end
            OVER: begin
                if (startBtn) begin
                    levelD = 4'd1;
                    winD   = 1'b0;
                    stateD = PRE;
                end
            end
            default: stateD = IDLE;
        endcase
        // every transition changes state, so entry is simply "state differs"
        enter = stateD != stateQ;
        secsD = enter ? phaseSecs(stateD) :
                (isTimed(stateQ) && secTick && secsLeft > 8'd1) ? secsLeft - 8'd1 : secsLeft;
    end

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            stateQ        <= IDLE;
            secsLeft      <= 8'd0;
            curLevel      <= 4'd1;
            win           <= 1'b0;
            waitQ         <= '0;
            prelimSig     <= 1'b0;
            gameSig       <= 1'b0;
            answerSig     <= 1'b0;
            postSig       <= 1'b0;
            startGen      <= 1'b0;
            stopGen       <= 1'b0;
            stopCount     <= 1'b0;
            levelComplete <= 1'b0;
            pre           <= 1'b0;
            game          <= 1'b0;
            answer        <= 1'b0;
            post          <= 1'b0;
            gameOver      <= 1'b0;
        end else begin
            stateQ        <= stateD;
            secsLeft      <= secsD;
            curLevel      <= levelD;
            win           <= winD;
            waitQ         <= enter ? '0 : waitD;
            prelimSig     <= enter && stateD == PRE;
            gameSig       <= enter && stateD == GAME;
            answerSig     <= enter && stateD == ANSWER;
            postSig       <= enter && stateD == POST;
            startGen      <= enter && stateD == GAME;
            stopGen       <= enter && stateD == ANSWER;
            stopCount     <= enter && stateD == POST;
            levelComplete <= enter && stateD == JUDGE;
            pre           <= stateD == PRE;
            game          <= stateD == GAME;
            answer        <= stateD == ANSWER;
            post          <= stateD == POST;
            gameOver      <= stateD == OVER;
        end
    end
endmodule

// File: tb/tb_period_sequencer.sv
// tb_period_sequencer: directed stimulus with a phase-level model checked every cycle
module tb_period_sequencer;
    logic       Clk100M = 1'b0, reset = 1'b1, Clk1Hz = 1'b0;
    logic       startBtn = 1'b0, incLevel = 1'b0, lose = 1'b0;
    logic       prelimSig, gameSig, answerSig, postSig, startGen, stopGen, stopCount;
    logic       levelComplete, pre, game, answer, post, gameOver, win;
    logic [7:0] secsLeft;
    logic [3:0] curLevel;

    period_sequencer dut (
        .Clk100M(Clk100M), .reset(reset), .Clk1Hz(Clk1Hz), .startBtn(startBtn),
        .incLevel(incLevel), .lose(lose), .prelimSig(prelimSig), .gameSig(gameSig),
        .answerSig(answerSig), .postSig(postSig), .startGen(startGen), .stopGen(stopGen),
        .stopCount(stopCount), .levelComplete(levelComplete), .pre(pre), .game(game),
        .answer(answer), .post(post), .secsLeft(secsLeft), .curLevel(curLevel),
        .gameOver(gameOver), .win(win)
    );

    always #5 Clk100M = ~Clk100M;

    int checks = 0, failures = 0;
    bit started = 1'b0;

    // phases: 0 idle, 1 pre, 2 game, 3 answer, 4 post, 5 judge, 6 over
    int dur[7] = '{0, 3, 10, 5, 3, 0, 0};
    int mPh = 0, mEnt = -1, mSecs = 0, mLevel = 1, mWait = 0, cyc = 0;
    bit mWin = 1'b0, prevRaw = 1'b0;
    int tickQ[$];

    // a raw Clk1Hz rise first sampled at edge k is acted on at edge k+3
    initial forever begin
        @(posedge Clk100M);
        cyc++;
        if (reset) begin
            mPh = 0; mEnt = -1; mSecs = 0; mLevel = 1; mWin = 1'b0; mWait = 0;
            prevRaw = 1'b0;
            tickQ.delete();
        end else begin
            bit tickNow;
            int nxt;
            tickNow = tickQ.size() > 0 && tickQ[0] == cyc;
            if (tickNow) void'(tickQ.pop_front());
            if (Clk1Hz && !prevRaw) tickQ.push_back(cyc + 3);
            prevRaw = Clk1Hz;
            nxt = mPh;
            mEnt = -1;
            if (mPh == 0) begin
                if (startBtn) nxt = 1;
            end else if (mPh <= 4) begin
                if (tickNow) begin
                    if (mSecs == 1) nxt = mPh + 1;
                    else mSecs--;
                end
            end else if (mPh == 5) begin
                if (lose) begin nxt = 6; mWin = 1'b0; end
                else if (incLevel) begin
                    if (mLevel < 9) begin mLevel++; nxt = 1; end
                    else begin nxt = 6; mWin = 1'b1; end
                end else begin
                    mWait++;
                    if (mWait >= 16) nxt = 6;
                end
            end else if (startBtn) begin
                mLevel = 1; mWin = 1'b0; nxt = 1;
            end
            if (nxt != mPh) begin
                mEnt = nxt; mSecs = dur[nxt]; mWait = 0; mPh = nxt;
            end
        end
    end

    initial forever begin
        logic [25:0] gotV, expV;
        @(negedge Clk100M);
        if (started) begin
            gotV = {prelimSig, gameSig, answerSig, postSig, startGen, stopGen, stopCount,
                    levelComplete, pre, game, answer, post, gameOver, win, curLevel, secsLeft};
            expV = {mEnt == 1, mEnt == 2, mEnt == 3, mEnt == 4, mEnt == 2, mEnt == 3, mEnt == 4,
                    mEnt == 5, mPh == 1, mPh == 2, mPh == 3, mPh == 4, mPh == 6, mWin,
                    4'(mLevel), 8'(mSecs)};
            checks++;
            if (gotV !== expV) begin
                failures++;
                $display("FAIL model_compare t=%0t got=%h expected=%h", $time, gotV, expV);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        Clk1Hz = 1'b1;
        repeat (2) @(negedge Clk100M);
        Clk1Hz = 1'b0;
        repeat (2) @(negedge Clk100M);
    endtask

    task automatic press(input logic s, input logic i, input logic l);
        startBtn = s; incLevel = i; lose = l;
        @(negedge Clk100M);
        startBtn = 1'b0; incLevel = 1'b0; lose = 1'b0;
    endtask

    task automatic runLevel();
        repeat (21) tick();
    endtask

    initial begin
        repeat (3) @(negedge Clk100M);
        started = 1'b1;
        reset = 1'b0;
        chk("reset_level", int'(curLevel), 1);
        chk("reset_secs", int'(secsLeft), 0);
        chk("reset_over", int'(gameOver), 0);
        press(1, 0, 0);
        chk("start_prelim", int'(prelimSig), 1);
        chk("start_pre", int'(pre), 1);
        chk("start_secs", int'(secsLeft), 3);
        repeat (3) tick();
        chk("game_sig", int'({gameSig, startGen, game}), 7);
        chk("game_secs", int'(secsLeft), 10);
        repeat (10) tick();
        chk("answer_sig", int'({answerSig, stopGen, answer}), 7);
        repeat (5) tick();
        chk("post_sig", int'({postSig, stopCount, post}), 7);
        repeat (3) tick();
        chk("judge_entry", int'(levelComplete), 1);
        press(0, 1, 0);
        chk("inc_level", int'(curLevel), 2);
        chk("inc_prelim", int'(prelimSig), 1);
        chk("inc_secs", int'(secsLeft), 3);
        runLevel();
        press(0, 1, 1);
        chk("both_over", int'({gameOver, win}), 2);
        chk("both_level", int'(curLevel), 2);
        press(1, 0, 0);
        chk("restart_level", int'(curLevel), 1);
        for (int l = 1; l < 9; l++) begin
            runLevel();
            press(0, 1, 0);
        end
        chk("reach_max", int'(curLevel), 9);
        runLevel();
        press(0, 1, 0);
        chk("win_over", int'({gameOver, win}), 3);
        chk("win_level", int'(curLevel), 9);
        press(1, 0, 0);
        chk("restart_win_clr", int'(win), 0);
        runLevel();
        repeat (15) @(negedge Clk100M);
        chk("judge_wait15", int'(gameOver), 0);
        @(negedge Clk100M);
        chk("judge_timeout", int'({gameOver, win}), 2);
        press(1, 0, 0);
        runLevel();
        press(0, 1, 0);
        repeat (3) tick();
        press(1, 0, 0);
        chk("btn_in_game", int'({game, prelimSig}), 2);
        press(0, 0, 1);
        chk("lose_in_game", int'({game, gameOver}), 2);
        repeat (9) tick();
        Clk1Hz = 1'b1;
        repeat (2) @(negedge Clk100M);
        Clk1Hz = 1'b0;
        @(negedge Clk100M);
        reset = 1'b1;
        @(negedge Clk100M);
        chk("rst_no_stopgen", int'({stopGen, answerSig, answer}), 0);
        chk("rst_flags", int'({pre, game, post, gameOver}), 0);
        chk("rst_level", int'(curLevel), 1);
        chk("rst_secs", int'(secsLeft), 0);
        reset = 1'b0;
        repeat (2) @(negedge Clk100M);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
